spi_slave: RTL and testbench
============================

# spi_slave

SPI slave endpoint sitting directly downstream of `spi_master`, on the far end of the `sck`/`mosi`/`ssn`/`miso` wires. It oversamples the serial bus in the system `clk` domain, deserialises 8-bit frames into `data_r_s`, and serialises `data_s` back onto `miso`. It supports all four CPOL/CPHA modes and uses the same `spcon` bit layout as the master, so one control byte configures both ends of the link.

## Interface
- `SYNC_STAGES`, 2: synchroniser depth for `sck`, `mosi` and `ssn`; minimum 2.
- `clk`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset, synchronous, active-high.
- `spcon`  in  8  control byte:
  - bit6 SPEN: 1 enables the block.
  - bit3 CPOL.
  - bit2 CPHA.
  - All other bits are reserved and ignored.
- `data_s`  in  8  transmit byte; latched at frame start and at every byte boundary.
- `sck`  in  1  serial clock from the master, asynchronous to `clk`.
- `mosi`  in  1  serial data from the master, MSB first.
- `ssn`  in  1  slave select, active-low; driven from one bit of the master's `ssn` bus.
- `miso`  out  1  serial data to the master, MSB first; registered.
- `miso_oe`  out  1  tri-state enable for `miso`; 1 while selected.
- `data_r_s`  out  8  last complete received byte.
- `rx_valid`  out  1  one-cycle strobe; `data_r_s` was just updated.
- `busy`  out  1  high while a frame is in progress.

## Operation
- **Synchronisation**
  - `sck`, `mosi` and `ssn` each pass through `SYNC_STAGES` flops to give `sck_s`, `mosi_s`, `ssn_s`.
  - One further register on `sck_s` provides edge detection.
  - Leading edge: `sck_s` leaves the CPOL level. Trailing edge: `sck_s` returns to the CPOL level.
  - Sample edge: leading when CPHA=0, trailing when CPHA=1. The other edge is the shift edge.
- **FSM states:** IDLE, ACTIVE.
  - IDLE -> ACTIVE when SPEN=1 and `ssn_s` is seen falling. That cycle:
    - CPOL and CPHA are captured into internal mode registers, which hold for the whole frame.
    - `data_s` is latched into `tx_sr`.
    - Bit count is cleared to 0.
    - `busy` and `miso_oe` are set to 1.
    - If CPHA=0, `miso` is set to `data_s[7]` in the same cycle.
  - ACTIVE -> IDLE when `ssn_s` is 1 or SPEN=0. That cycle:
    - Bit count is cleared.
    - `busy`, `miso_oe` and `miso` go to 0.
    - A partial byte is discarded: `data_r_s` is unchanged and `rx_valid` is not pulsed.
- **Sample edge (ACTIVE):**
  - `rx_sr <= {rx_sr[6:0], mosi_s}`.
  - Bit count increments modulo 8.
  - On the 8th sample, `data_r_s <= {rx_sr[6:0], mosi_s}` and `rx_valid` = 1 on the next cycle only.
- **Shift edge (ACTIVE):**
  - CPHA=0: `miso` takes the next bit of `tx_sr`.
  - CPHA=1: `miso` takes the current bit, starting with bit7 on the first leading edge.
  - After bit0 has been shifted out, `tx_sr` reloads from `data_s`. This supports back-to-back bytes while `ssn` stays low: with CPHA=0, the next byte's bit7 appears on the 8th trailing edge.
- **Simultaneous events:** an `ssn_s` rise takes priority over any `sck` edge in the same cycle; that edge is ignored.
- **SPEN=0:**
  - All bus activity is ignored.
  - Outputs hold their reset values, except `data_r_s`, which retains its value.

## Timing
- Reset values:
  - `miso`=0, `miso_oe`=0, `data_r_s`=8'h00, `rx_valid`=0, `busy`=0.
  - Internal: `tx_sr`=0, `rx_sr`=0, count=0, FSM in IDLE.
  - A `rst` assertion mid-frame returns all of the above in one cycle; the partial frame is lost.
- Input-to-action latency is `SYNC_STAGES`+1 `clk` cycles, i.e. 3 at the default. This applies to `ssn` pin fall -> `busy`/`miso_oe`/first `miso` bit, and to `sck` pin edge -> sample/shift.
- `rx_valid` rises 1 cycle after the internal 8th sample edge, i.e. `SYNC_STAGES`+2 cycles after the pin edge.
- `sck` high and low phases must each be at least 2·`SYNC_STAGES`+2 `clk` cycles. Faster `sck` is outside this block's operating range, and its behaviour is undefined.
- With CPHA=0, the first `sck` edge must arrive at least `SYNC_STAGES`+2 cycles after `ssn` falls.
- `data_s` must be stable from 1 cycle before the reload point; it is sampled only at frame start and at byte boundaries.

## Test plan
- **Mode 0, single byte:** `spcon`=8'h40, `data_s`=8'hA5, master sends 8'h3C at `sck` half-period 8 -> `data_r_s`=8'h3C with a single-cycle `rx_valid`; master receives 8'hA5 on `miso`.
- **All four modes:** `spcon` = 8'h40, 8'h44, 8'h48, 8'h4C, each with tx 8'h81 and rx 8'h7E -> correct bytes on both ends in every mode.
- **Back-to-back:** `ssn` held low, master sends 8'h01 then 8'hFF; `data_s` changes to 8'h55 before byte 2 -> two `rx_valid` pulses carrying 8'h01 and 8'hFF; `miso` carries the first `data_s` byte, then 8'h55.
- **Abort:** `ssn` rises after 5 bits -> no `rx_valid`; `data_r_s` keeps its prior value; `busy`, `miso_oe` and `miso` all 0 within 3 cycles; the next full frame is received correctly.
- **Reset and disable:**
  - `rst`=1 mid-frame -> all outputs at their reset values on the next cycle.
  - `spcon`=8'h00 with bus toggling -> `busy`=0 and `rx_valid` never asserted.

Source files
------------

// File: rtl/spi_slave.sv
// SPI slave endpoint: oversamples sck/mosi/ssn in the clk domain, receives 8-bit
// frames into data_r_s and returns data_s on miso, in any CPOL/CPHA mode.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] spcon,
    input  logic [7:0] data_s,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ssn,
    output logic       miso,
    output logic       miso_oe,
    output logic [7:0] data_r_s,
    output logic       rx_valid,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] ssn_sync;
    logic                   sck_d;
    logic                   ssn_d;
    logic                   cpol_m;
    logic                   cpha_m;
    logic [7:0]             tx_sr;
    logic [7:0]             rx_sr;
    logic [2:0]             bit_cnt;
    logic                   rx_done;

    logic sck_s;
    logic mosi_s;
    logic ssn_s;
    logic spen;
    logic lead_edge;
    logic trail_edge;
    logic sample_edge;
    logic shift_edge;
    logic spcon_unused;

    assign sck_s  = sck_sync[SYNC_STAGES-1];
    assign mosi_s = mosi_sync[SYNC_STAGES-1];
    assign ssn_s  = ssn_sync[SYNC_STAGES-1];
    assign spen   = spcon[6];
    assign spcon_unused = ^{spcon[7], spcon[5:4], spcon[1:0]};

    // Edges are judged against the CPOL captured at frame start, not the live spcon.
    assign lead_edge   = (sck_s != cpol_m) && (sck_d == cpol_m);
    assign trail_edge  = (sck_s == cpol_m) && (sck_d != cpol_m);
    assign sample_edge = cpha_m ? trail_edge : lead_edge;
    assign shift_edge  = cpha_m ? lead_edge : trail_edge;

    always_ff @(posedge clk) begin
        if (rst) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ssn_sync  <= '1;
            sck_d     <= 1'b0;
            ssn_d     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            ssn_sync  <= {ssn_sync[SYNC_STAGES-2:0], ssn};
            sck_d     <= sck_s;
            ssn_d     <= ssn_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cpol_m   <= 1'b0;
            cpha_m   <= 1'b0;
            tx_sr    <= 8'h00;
            rx_sr    <= 8'h00;
            bit_cnt  <= 3'd0;
            rx_done  <= 1'b0;
            miso     <= 1'b0;
            miso_oe  <= 1'b0;
            data_r_s <= 8'h00;
            rx_valid <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_done  <= 1'b0;
            rx_valid <= rx_done && spen;
            case (state)
                IDLE: begin
                    if (spen && ssn_d && !ssn_s) begin
                        state   <= ACTIVE;
                        cpol_m  <= spcon[3];
                        cpha_m  <= spcon[2];
                        tx_sr   <= data_s;
                        bit_cnt <= 3'd0;
                        busy    <= 1'b1;
                        miso_oe <= 1'b1;
                        miso    <= spcon[2] ? 1'b0 : data_s[7];
                    end
                end
                ACTIVE: begin
                    // Deselect or disable wins over any sck edge in the same cycle.
                    if (ssn_s || !spen) begin
                        state   <= IDLE;
                        bit_cnt <= 3'd0;
                        busy    <= 1'b0;
                        miso_oe <= 1'b0;
                        miso    <= 1'b0;
                    end else begin
                        if (sample_edge) begin
                            rx_sr   <= {rx_sr[6:0], mosi_s};
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) begin
                                data_r_s <= {rx_sr[6:0], mosi_s};
                                rx_done  <= 1'b1;
                            end
                        end
                        // A zero count on a CPHA=0 shift edge means the 8th bit is done.
                        if (shift_edge) begin
                            if (!cpha_m) begin
                                if (bit_cnt == 3'd0) begin
                                    tx_sr <= data_s;
                                    miso  <= data_s[7];
                                end else begin
                                    tx_sr <= {tx_sr[6:0], 1'b0};
                                    miso  <= tx_sr[6];
                                end
                            end else begin
                                miso <= tx_sr[7];
                                if (bit_cnt == 3'd7) begin
                                    tx_sr <= data_s;
                                end else begin
                                    tx_sr <= {tx_sr[6:0], 1'b0};
                                end
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: acts as the SPI master and checks both directions of the link
// against the bytes it chose to send, plus reset, abort and disable behaviour.
module tb_spi_slave;

    localparam int H = 8;

    logic       clk;
    logic       rst;
    logic [7:0] spcon;
    logic [7:0] data_s;
    logic       sck;
    logic       mosi;
    logic       ssn;
    logic       miso;
    logic       miso_oe;
    logic [7:0] data_r_s;
    logic       rx_valid;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int         pulse_cnt = 0;
    int         wide_cnt  = 0;
    int         busy_cnt  = 0;
    int         oe_cnt    = 0;
    logic       prev_v    = 1'b0;
    logic [7:0] rx_log[$];

    typedef struct {
        logic [7:0] spcon_v;
        logic [7:0] slave_tx;
        logic [7:0] master_tx;
        logic [7:0] exp_data_r;
        logic [7:0] exp_master_rx;
    } vec_t;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .spcon    (spcon),
        .data_s   (data_s),
        .sck      (sck),
        .mosi     (mosi),
        .ssn      (ssn),
        .miso     (miso),
        .miso_oe  (miso_oe),
        .data_r_s (data_r_s),
        .rx_valid (rx_valid),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive monitor: logs every received byte and counts activity cycles.
    always @(negedge clk) begin
        if (rx_valid) begin
            pulse_cnt++;
            rx_log.push_back(data_r_s);
            if (prev_v) wide_cnt++;
        end
        prev_v = rx_valid;
        if (busy) busy_cnt++;
        if (miso_oe) oe_cnt++;
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Master side of one frame; data_s switches to d1 just before bit change_at.
    task automatic applyStimulus(input logic [7:0] spcon_v, input logic [15:0] mbits,
                                 input int nbits, input logic [7:0] d0, input logic [7:0] d1,
                                 input int change_at, input bit release_ssn,
                                 output logic [15:0] got);
        logic cpol;
        logic cpha;
        cpol   = spcon_v[3];
        cpha   = spcon_v[2];
        got    = 16'h0000;
        spcon  = spcon_v;
        data_s = d0;
        sck    = cpol;
        mosi   = 1'b0;
        waitCycles(H);
        ssn = 1'b0;
        waitCycles(H);
        for (int i = 0; i < nbits; i++) begin
            if (i == change_at) data_s = d1;
            if (!cpha) begin
                mosi = mbits[nbits-1-i];
                waitCycles(H);
                sck = ~cpol;
                got = {got[14:0], miso};
                waitCycles(H);
                sck = cpol;
            end else begin
                sck  = ~cpol;
                mosi = mbits[nbits-1-i];
                waitCycles(H);
                sck = cpol;
                got = {got[14:0], miso};
                waitCycles(H);
            end
        end
        if (release_ssn) begin
            waitCycles(H);
            ssn = 1'b1;
            waitCycles(H);
        end
    endtask

    initial begin
        vec_t        vecs[5];
        logic [15:0] got;
        int          base;
        int          wbase;
        int          bbase;
        int          obase;
        logic [7:0]  m0, m1, s0, s1, sp;
        int          nb;

        vecs[0] = '{8'h40, 8'hA5, 8'h3C, 8'h3C, 8'hA5};
        vecs[1] = '{8'h40, 8'h81, 8'h7E, 8'h7E, 8'h81};
        vecs[2] = '{8'h44, 8'h81, 8'h7E, 8'h7E, 8'h81};
        vecs[3] = '{8'h48, 8'h81, 8'h7E, 8'h7E, 8'h81};
        vecs[4] = '{8'h4C, 8'h81, 8'h7E, 8'h7E, 8'h81};

        rst    = 1'b1;
        spcon  = 8'h00;
        data_s = 8'h00;
        sck    = 1'b0;
        mosi   = 1'b0;
        ssn    = 1'b1;
        waitCycles(4);
        checkOutput("reset_miso", int'(miso), 0);
        checkOutput("reset_miso_oe", int'(miso_oe), 0);
        checkOutput("reset_data_r_s", int'(data_r_s), 0);
        checkOutput("reset_rx_valid", int'(rx_valid), 0);
        checkOutput("reset_busy", int'(busy), 0);
        rst = 1'b0;
        waitCycles(4);

        // ssn fall to busy/miso_oe/first bit takes exactly three cycles.
        spcon  = 8'h40;
        data_s = 8'hA5;
        waitCycles(H);
        ssn = 1'b0;
        waitCycles(2);
        checkOutput("latency_busy_early", int'(busy), 0);
        waitCycles(1);
        checkOutput("latency_busy", int'(busy), 1);
        checkOutput("latency_miso_oe", int'(miso_oe), 1);
        checkOutput("latency_miso", int'(miso), 1);
        ssn = 1'b1;
        waitCycles(H);
        checkOutput("empty_frame_busy", int'(busy), 0);

        for (int v = 0; v < 5; v++) begin
            base  = pulse_cnt;
            wbase = wide_cnt;
            applyStimulus(vecs[v].spcon_v, {8'h00, vecs[v].master_tx}, 8,
                          vecs[v].slave_tx, vecs[v].slave_tx, 99, 1'b1, got);
            checkOutput("vec_rx_pulses", pulse_cnt - base, 1);
            checkOutput("vec_pulse_width", wide_cnt - wbase, 0);
            checkOutput("vec_data_r_s", int'(data_r_s), int'(vecs[v].exp_data_r));
            checkOutput("vec_master_rx", int'(got[7:0]), int'(vecs[v].exp_master_rx));
            checkOutput("vec_busy_after", int'(busy), 0);
        end

        // Back-to-back bytes with data_s updated during the first byte.
        base = pulse_cnt;
        applyStimulus(8'h40, 16'h01FF, 16, 8'hC3, 8'h55, 4, 1'b1, got);
        checkOutput("b2b_pulses", pulse_cnt - base, 2);
        if (pulse_cnt - base >= 2) begin
            checkOutput("b2b_byte0", int'(rx_log[base]), 8'h01);
            checkOutput("b2b_byte1", int'(rx_log[base+1]), 8'hFF);
        end
        checkOutput("b2b_master_rx", int'(got), 16'hC355);

        // Reset mid-frame.
        applyStimulus(8'h40, 16'h00F0, 4, 8'hFF, 8'hFF, 99, 1'b0, got);
        rst = 1'b1;
        ssn = 1'b1;
        sck = 1'b0;
        waitCycles(1);
        checkOutput("midrst_miso", int'(miso), 0);
        checkOutput("midrst_miso_oe", int'(miso_oe), 0);
        checkOutput("midrst_data_r_s", int'(data_r_s), 0);
        checkOutput("midrst_rx_valid", int'(rx_valid), 0);
        checkOutput("midrst_busy", int'(busy), 0);
        waitCycles(4);
        rst = 1'b0;
        waitCycles(4);

        // Abort after five bits, then a clean frame.
        applyStimulus(8'h40, 16'h005A, 8, 8'h11, 8'h11, 99, 1'b1, got);
        checkOutput("pre_abort_data", int'(data_r_s), 8'h5A);
        base = pulse_cnt;
        applyStimulus(8'h40, 16'h0013, 5, 8'hFF, 8'hFF, 99, 1'b0, got);
        ssn = 1'b1;
        waitCycles(3);
        checkOutput("abort_busy", int'(busy), 0);
        checkOutput("abort_miso_oe", int'(miso_oe), 0);
        checkOutput("abort_miso", int'(miso), 0);
        waitCycles(H);
        checkOutput("abort_pulses", pulse_cnt - base, 0);
        checkOutput("abort_data_kept", int'(data_r_s), 8'h5A);
        applyStimulus(8'h40, 16'h00C6, 8, 8'h39, 8'h39, 99, 1'b1, got);
        checkOutput("post_abort_pulses", pulse_cnt - base, 1);
        checkOutput("post_abort_data", int'(data_r_s), 8'hC6);
        checkOutput("post_abort_master_rx", int'(got[7:0]), 8'h39);

        // Disabled block ignores a full frame of bus activity.
        base  = pulse_cnt;
        bbase = busy_cnt;
        obase = oe_cnt;
        applyStimulus(8'h00, 16'h00A5, 8, 8'hFF, 8'hFF, 99, 1'b1, got);
        checkOutput("disable_pulses", pulse_cnt - base, 0);
        checkOutput("disable_busy_cycles", busy_cnt - bbase, 0);
        checkOutput("disable_oe_cycles", oe_cnt - obase, 0);
        checkOutput("disable_data_kept", int'(data_r_s), 8'hC6);

        // Random frames: one or two bytes, any mode, reserved spcon bits scrambled.
        for (int f = 0; f < 16; f++) begin
            sp = 8'h40 | 8'($urandom_range(0, 3) << 2) | (8'($urandom) & 8'hB3);
            nb = $urandom_range(1, 2);
            m0 = 8'($urandom);
            m1 = 8'($urandom);
            s0 = 8'($urandom);
            s1 = 8'($urandom);
            base  = pulse_cnt;
            wbase = wide_cnt;
            applyStimulus(sp, (nb == 2) ? {m0, m1} : {8'h00, m0}, nb * 8, s0, s1, 2, 1'b1, got);
            checkOutput("rand_pulses", pulse_cnt - base, nb);
            checkOutput("rand_pulse_width", wide_cnt - wbase, 0);
            if (pulse_cnt - base >= nb) begin
                checkOutput("rand_byte0", int'(rx_log[base]), int'(m0));
                if (nb == 2) checkOutput("rand_byte1", int'(rx_log[base+1]), int'(m1));
            end
            if (nb == 2) checkOutput("rand_master_rx", int'(got), int'({s0, s1}));
            else         checkOutput("rand_master_rx", int'(got[7:0]), int'(s0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
